// File: rtl/if_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack handshake plus the IF/ID-facing head and control.
// master = fetch unit, slave = memory/pipeline environment.
interface if_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              jump_stall_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              full_stall;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] pc_addr;
    logic              valid;

    modport master (
        input  jump_stall_en, jump_addr, full_stall, imem_ack, imem_rdata,
        output imem_req, imem_addr, inst, pc_addr, valid
    );

    modport slave (
        output jump_stall_en, jump_addr, full_stall, imem_ack, imem_rdata,
        input  imem_req, imem_addr, inst, pc_addr, valid
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch producer: owns the PC, fetches over req/ack into a small FIFO feeding IF/ID.
// Optional IF_FETCH_PERF_EN adds fetch/squash performance counters.
//   state   | meaning
//   S_IDLE  | no request outstanding; waits for FIFO room
//   S_REQ   | request for r_pc outstanding
//   S_DRAIN | redirected while waiting; old request still outstanding, its data is dropped
module if_fetch #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0]  o_perf_fetch_cnt,
    output logic [31:0]  o_perf_squash_cnt,
`endif
    if_fetch_if.master   bus
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       inst;
    } entry_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] r_drain_addr;
    entry_t            r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_after;
    logic              w_jump;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    entry_t            w_head;
    logic              w_unused;

    assign w_jump   = bus.jump_stall_en;
    assign w_push   = (r_state == S_REQ) && bus.imem_ack && !w_jump;
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid && !bus.full_stall && !w_jump;
    assign w_count_after = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_head   = r_mem[r_rd_ptr];
    // Redirect targets are word aligned; the low address bits are ignored.
    assign w_unused = ^bus.jump_addr[1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_jump || (r_count < DEPTH_C)) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (w_jump)                w_state_nxt = bus.imem_ack ? S_REQ : S_DRAIN;
                else if (bus.imem_ack)     w_state_nxt = (w_count_after < DEPTH_C) ? S_REQ : S_IDLE;
            end
            S_DRAIN: begin
                if (bus.imem_ack) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pc_nxt = r_pc;
        if (w_jump)      w_pc_nxt = {bus.jump_addr[ADDR_W-1:2], 2'b00};
        else if (w_push) w_pc_nxt = r_pc + ADDR_W'(4);
    end

    always_comb begin
        bus.imem_req  = (r_state != S_IDLE);
        bus.imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
        bus.valid     = w_valid;
        bus.inst      = w_valid ? w_head.inst : 32'd0;
        bus.pc_addr   = w_valid ? w_head.pc : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            // Keep presenting the outstanding address while the redirected pc moves on.
            if ((r_state == S_REQ) && w_jump && !bus.imem_ack) r_drain_addr <= r_pc;
            if (w_jump) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= w_count_after;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{pc: r_pc, inst: bus.imem_rdata};
    end

`ifdef IF_FETCH_PERF_EN
    logic        w_discard;
    logic [31:0] w_squash_inc;

    assign w_discard    = bus.imem_ack && ((r_state == S_DRAIN) || ((r_state == S_REQ) && w_jump));
    assign w_squash_inc = 32'(w_discard) + (w_jump ? 32'(r_count) : 32'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_perf_fetch_cnt  <= '0;
            o_perf_squash_cnt <= '0;
        end else begin
            if (w_push) o_perf_fetch_cnt <= o_perf_fetch_cnt + 32'd1;
            o_perf_squash_cnt <= o_perf_squash_cnt + w_squash_inc;
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: queue-based fetch model checked every cycle, plus directed literal checks.
// Define IF_FETCH_PERF_EN to also check the performance counters.
module tb_if_fetch;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] RST_PC    = 32'h0000_0000;
    localparam logic [31:0] SLOW_ADDR = 32'h0000_0010;
    localparam logic [31:0] XORPAT    = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    if_fetch_if #(.ADDR_W(32)) bus ();

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_squash_cnt;
`endif

    if_fetch #(.ADDR_W(32), .RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
`ifdef IF_FETCH_PERF_EN
        .o_perf_fetch_cnt (perf_fetch_cnt),
        .o_perf_squash_cnt(perf_squash_cnt),
`endif
        .bus              (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        m_q[$];
    bit          m_init    = 0;
    bit          m_busy    = 0;
    bit          m_discard = 0;
    logic [31:0] m_pc      = RST_PC;
    logic [31:0] m_addr    = RST_PC;
    logic [31:0] m_fetch   = 0;
    logic [31:0] m_squash  = 0;

    always @(posedge clk) begin : model
        int n0;
        bit ack_hit;
        if (rst) begin
            m_q.delete();
            m_busy = 0; m_discard = 0;
            m_pc = RST_PC; m_addr = RST_PC;
            m_fetch = 0; m_squash = 0;
            m_init = 1;
        end else if (m_init) begin
            n0 = m_q.size();
            ack_hit = m_busy && bus.imem_ack;
            if (bus.jump_stall_en) begin
                if (ack_hit) m_squash = m_squash + 1;
                m_squash = m_squash + 32'(n0);
                m_q.delete();
                m_pc = {bus.jump_addr[31:2], 2'b00};
                if (ack_hit || !m_busy) begin
                    m_busy = 1; m_addr = m_pc; m_discard = 0;
                end else begin
                    m_discard = 1;
                end
            end else begin
                if (n0 > 0 && !bus.full_stall) void'(m_q.pop_front());
                if (ack_hit) begin
                    if (m_discard) begin
                        m_squash = m_squash + 1;
                        m_discard = 0;
                        m_addr = m_pc;
                    end else begin
                        m_q.push_back('{pc: m_addr, inst: m_addr ^ XORPAT});
                        m_fetch = m_fetch + 1;
                        m_pc = m_addr + 32'd4;
                        m_busy = (m_q.size() < DEPTH);
                        m_addr = m_pc;
                    end
                end else if (!m_busy && n0 < DEPTH) begin
                    m_busy = 1; m_addr = m_pc;
                end
            end
        end
    end

    bit watch_10 = 0;
    bit saw_10   = 0;

    always @(negedge clk) begin : compare
        logic [31:0] e_addr, e_inst, e_pc;
        bit e_valid;
        if (m_init && !rst) begin
            e_valid = (m_q.size() != 0);
            e_inst  = e_valid ? m_q[0].inst : 32'd0;
            e_pc    = e_valid ? m_q[0].pc : 32'd0;
            e_addr  = m_busy ? m_addr : m_pc;
            chk("req", 32'(bus.imem_req), 32'(m_busy));
            chk("addr", bus.imem_addr, e_addr);
            chk("valid", 32'(bus.valid), 32'(e_valid));
            chk("inst", bus.inst, e_inst);
            chk("pc_addr", bus.pc_addr, e_pc);
`ifdef IF_FETCH_PERF_EN
            chk("perf_fetch", perf_fetch_cnt, m_fetch);
            chk("perf_squash", perf_squash_cnt, m_squash);
`endif
            if (watch_10 && bus.valid && bus.pc_addr == SLOW_ADDR) saw_10 = 1;
        end
    end

    // ---------------- stimulus ----------------
    bit slow_mode = 0;
    int wait_cnt  = 0;

    task automatic tick(input logic j, input logic [31:0] ja, input logic st, input logic ak);
        int nxt;
        bit slow_hit;
        bus.jump_stall_en = j;
        bus.jump_addr     = ja;
        bus.full_stall    = st;
        slow_hit = slow_mode && bus.imem_req && (bus.imem_addr == SLOW_ADDR);
        bus.imem_ack   = slow_hit ? (wait_cnt >= 2) : ak;
        bus.imem_rdata = bus.imem_addr ^ XORPAT;
        nxt = (slow_hit && !bus.imem_ack) ? wait_cnt + 1 : 0;
        @(posedge clk);
        wait_cnt = nxt;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bus.jump_stall_en = 0; bus.jump_addr = 0; bus.full_stall = 0;
        bus.imem_ack = 0; bus.imem_rdata = 0;
        #1;
        tick(0, 0, 0, 0);
        do_reset();

        // reset state
        chk("rst_req", 32'(bus.imem_req), 0);
        chk("rst_addr", bus.imem_addr, RST_PC);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_pc_addr", bus.pc_addr, 0);

        // streaming with ack tied high
        tick(0, 0, 0, 1);
        chk("s1_req", 32'(bus.imem_req), 1);
        chk("s1_addr", bus.imem_addr, 32'h0);
        chk("s1_valid", 32'(bus.valid), 0);
        tick(0, 0, 0, 1);
        chk("s2_valid", 32'(bus.valid), 1);
        chk("s2_inst", bus.inst, 32'hA5A5_A5A5);
        chk("s2_pc", bus.pc_addr, 32'h0);
        chk("s2_addr", bus.imem_addr, 32'h4);
        tick(0, 0, 0, 1);
        chk("s3_pc", bus.pc_addr, 32'h4);
        chk("s3_inst", bus.inst, 32'hA5A5_A5A1);
        chk("s3_addr", bus.imem_addr, 32'h8);

        // full_stall fills the buffer then stops requesting
        do_reset();
        repeat (6) tick(0, 0, 1, 1);
        chk("st_valid", 32'(bus.valid), 1);
        chk("st_pc", bus.pc_addr, 32'h0);
        chk("st_req", 32'(bus.imem_req), 0);
        chk("st_addr", bus.imem_addr, 32'h8);
        tick(0, 0, 0, 1);
        chk("st_pc1", bus.pc_addr, 32'h4);
        tick(0, 0, 0, 1);
        chk("st_resume_req", 32'(bus.imem_req), 1);
        chk("st_resume_addr", bus.imem_addr, 32'h8);
        tick(0, 0, 0, 1);
        chk("st_pc8", bus.pc_addr, 32'h8);

        // slow memory at 0x10, redirect during the wait
        do_reset();
        slow_mode = 1; watch_10 = 1; saw_10 = 0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req && bus.imem_addr == SLOW_ADDR) begin
                found = 1;
                break;
            end
            tick(0, 0, 0, 1);
        end
        chk("reach_0x10", 32'(found), 1);
        tick(1, 32'h100, 0, 1);
        chk("dr_req", 32'(bus.imem_req), 1);
        chk("dr_addr0", bus.imem_addr, SLOW_ADDR);
        chk("dr_valid", 32'(bus.valid), 0);
        tick(0, 0, 0, 1);
        chk("dr_addr1", bus.imem_addr, SLOW_ADDR);
        tick(0, 0, 0, 1);
        chk("dr_new_addr", bus.imem_addr, 32'h100);
        chk("dr_drop", 32'(bus.valid), 0);
        tick(0, 0, 0, 1);
        chk("dr_first_pc", bus.pc_addr, 32'h100);
        chk("no_pc_0x10", 32'(saw_10), 0);
        slow_mode = 0; watch_10 = 0;

        // jump coinciding with ack, unaligned target
        tick(1, 32'h203, 0, 1);
        chk("ja_addr", bus.imem_addr, 32'h200);
        chk("ja_valid", 32'(bus.valid), 0);
        tick(0, 0, 0, 1);
        chk("ja_valid1", 32'(bus.valid), 1);
        chk("ja_pc", bus.pc_addr, 32'h200);
        chk("ja_inst", bus.inst, 32'hA5A5_A7A5);

        // reset in the middle of an outstanding request
        tick(0, 0, 1, 0);
        chk("mr_req_before", 32'(bus.imem_req), 1);
        chk("mr_valid_before", 32'(bus.valid), 1);
        rst = 1'b1;
        tick(0, 0, 1, 0);
        rst = 1'b0;
        chk("mr_valid", 32'(bus.valid), 0);
        chk("mr_inst", bus.inst, 0);
        chk("mr_req", 32'(bus.imem_req), 0);
        chk("mr_addr", bus.imem_addr, RST_PC);
        tick(0, 0, 0, 1);
        chk("mr_restart", bus.imem_addr, RST_PC);
        tick(0, 0, 0, 1);
        chk("mr_first_pc", bus.pc_addr, RST_PC);

        // mixed pattern of stalls, ack gaps and back-to-back jumps
        for (int i = 0; i < 40; i++)
            tick((i == 11) || (i == 12) || (i == 25) || (i == 33),
                 32'h400 + 32'(i) * 8 + 1,
                 (i % 5 == 3) || (i % 7 == 0),
                 (i % 3 != 1));

        // counter scenario: 10 fetches, flush of 2 entries, one discarded ack
        do_reset();
        repeat (10) tick(0, 0, 0, 1);
        tick(0, 0, 1, 1);
        chk("pf_full_valid", 32'(bus.valid), 1);
        tick(1, 32'h300, 1, 0);
        tick(1, 32'h340, 0, 0);
        tick(0, 0, 0, 1);
        chk("pf_next_addr", bus.imem_addr, 32'h340);
`ifdef IF_FETCH_PERF_EN
        chk("pf_fetch", perf_fetch_cnt, 32'd10);
        chk("pf_squash", perf_squash_cnt, 32'd3);
`endif
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
